// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the 1010 detector: valid/ready word in, one bit per clock out.
// Define BIT_SERIALIZER_LSB_FIRST_EN to emit in_data[0] first instead of the MSB.
module bit_serializer #(
   parameter int   WIDTH      = 4,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             frame_done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q,   cnt_d;

   logic             last_bit;
   logic             accept;
   logic             head_bit;
   logic [WIDTH-1:0] shifted;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
   assign head_bit = shift_q[0];
   assign shifted  = shift_q >> 1;
`else
   assign head_bit = shift_q[WIDTH-1];
   assign shifted  = shift_q << 1;
`endif

   assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
   // Held low while reset is asserted so no word is offered a handshake it cannot complete.
   assign in_ready = rst_n && ((state_q == ST_IDLE) || last_bit);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SHIFT;
               shift_d = in_data;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (last_bit) begin
               cnt_d = '0;
               if (accept) begin
                  shift_d = in_data;
               end else begin
                  state_d = ST_IDLE;
                  shift_d = shifted;
               end
            end else begin
               shift_d = shifted;
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy       = (state_q == ST_SHIFT);
   assign ser_valid  = busy;
   assign frame_done = last_bit;
   assign ser_out    = busy ? head_bit : IDLE_LEVEL;

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized and directed bench for bit_serializer against a queue-of-bits reference model.
module tb_bit_serializer;

   localparam int   W    = 4;
   localparam logic IDLE = 1'b0;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         ser_out;
   logic         ser_valid;
   logic         busy;
   logic         frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   bit_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic bit_at(input logic [W-1:0] w, input int k);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      return w[k];
`else
      return w[W-1-k];
`endif
   endfunction

   // Reference model: the bits still to be shown on ser_out, front = current cycle's bit.
   bit mq[$];
   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
      end else if (in_valid && mq.size() <= 1) begin
         if (mq.size() == 1) mq.pop_front();
         for (int k = 0; k < W; k++) mq.push_back(bit_at(in_data, k));
      end else if (mq.size() > 0) begin
         mq.pop_front();
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if ({in_ready, ser_out, ser_valid, busy, frame_done} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: got rdy/out/vld/busy/fd=%b, want 00000", c,
                     {in_ready, ser_out, ser_valid, busy, frame_done});
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, ser_out, ser_valid, busy, frame_done} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_release: got rdy/out/vld/busy/fd=%b, want 10000",
                  {in_ready, ser_out, ser_valid, busy, frame_done});
      end
      $display("test_reset done");
   endtask

   task automatic test_word(input string name, input logic [W-1:0] w,
                            input logic [W-1:0] exp_seq, input int exp_z);
      logic [W-1:0] got;
      int z;
      got = '0;
      @(negedge clk);
      in_valid = 1'b1; in_data = w;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         if (i == 0) in_valid = 1'b0;
         got[W-1-i] = ser_out;
         n_checks++;
         if ({ser_valid, busy, frame_done} !== {1'b1, 1'b1, (i == W-1)}) begin
            n_fail++;
            $display("FAIL %s_ctl bit%0d: got vld/busy/fd=%b, want %b", name, i,
                     {ser_valid, busy, frame_done}, {1'b1, 1'b1, (i == W-1)});
         end
      end
      n_checks++;
      if (got !== exp_seq) begin
         n_fail++;
         $display("FAIL %s_bits: got %b, want %b", name, got, exp_seq);
      end
      z = (got === 4'b1010) ? 1 : 0;
      n_checks++;
      if (z != exp_z) begin
         n_fail++;
         $display("FAIL %s_detect: got %0d matches, want %0d", name, z, exp_z);
      end
      @(negedge clk);
      n_checks++;
      if ({ser_out, ser_valid, busy, in_ready} !== {IDLE, 3'b001}) begin
         n_fail++;
         $display("FAIL %s_idle: got out/vld/busy/rdy=%b, want %b", name,
                  {ser_out, ser_valid, busy, in_ready}, {IDLE, 3'b001});
      end
      $display("%s word=%b bits=%b", name, w, got);
   endtask

   task automatic test_back_to_back();
      logic [2*W-1:0] got, want;
      logic [W-1:0] a, b;
      a = 4'b1010; b = 4'b0101;
      for (int k = 0; k < W; k++) begin
         want[2*W-1-k] = bit_at(a, k);
         want[W-1-k]   = bit_at(b, k);
      end
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready_c0: got %b, want 1", in_ready);
      end
      in_valid = 1'b1; in_data = a;
      for (int c = 1; c <= 2*W; c++) begin
         @(negedge clk);
         if (c == 1) in_data = b;
         if (c == W+1) in_valid = 1'b0;
         got[2*W-c] = ser_out;
         n_checks++;
         if ({ser_valid, in_ready} !== {1'b1, (c == W || c == 2*W)}) begin
            n_fail++;
            $display("FAIL b2b_cyc%0d: got vld/rdy=%b, want %b", c,
                     {ser_valid, in_ready}, {1'b1, (c == W || c == 2*W)});
         end
      end
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL b2b_bits: got %b, want %b", got, want);
      end
      @(negedge clk);
      n_checks++;
      if (ser_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: got vld=%b, want 0", ser_valid);
      end
      $display("test_back_to_back bits=%b", got);
   endtask

   task automatic test_backpressure();
      logic [2*W-1:0] got, want;
      logic [W-1:0] w;
      w = W'($urandom);
      for (int k = 0; k < W; k++) begin
         want[2*W-1-k] = bit_at(w, k);
         want[W-1-k]   = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b1; in_data = w;
      for (int c = 0; c < 2*W; c++) begin
         @(negedge clk);
         got[2*W-1-c] = ser_out;
         n_checks++;
         if (ser_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_gap cyc%0d: got vld=%b, want 1", c, ser_valid);
         end
         if (c >= 1 && c < W) begin
            n_checks++;
            if (in_ready !== (c == W-1)) begin
               n_fail++;
               $display("FAIL bp_ready cyc%0d: got %b, want %b", c, in_ready, (c == W-1));
            end
         end
         if (c == 0) in_valid = 1'b0;
         if (c == 1) begin in_valid = 1'b1; in_data = '1; end
         if (c == W) in_valid = 1'b0;
      end
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL bp_bits: got %b, want %b", got, want);
      end
      @(negedge clk);
      $display("test_backpressure word=%h bits=%b", w, got);
   endtask

   task automatic test_reset_mid_word();
      @(negedge clk);
      in_valid = 1'b1; in_data = W'($urandom);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ser_out, ser_valid, busy, in_ready} !== {IDLE, 3'b000}) begin
         n_fail++;
         $display("FAIL midrst: got out/vld/busy/rdy=%b, want %b",
                  {ser_out, ser_valid, busy, in_ready}, {IDLE, 3'b000});
      end
      rst_n = 1'b1;
      for (int c = 0; c < W; c++) begin
         @(negedge clk);
         n_checks++;
         if ({ser_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_after cyc%0d: got vld/rdy=%b, want 01", c, {ser_valid, in_ready});
         end
      end
      $display("test_reset_mid_word done");
   endtask

   task automatic test_random();
      bit take;
      logic [4:0] exp;
      take = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         exp = {(mq.size() != 0) ? mq[0] : IDLE, mq.size() != 0, mq.size() != 0,
                mq.size() == 1, rst_n && (mq.size() <= 1)};
         n_checks++;
         if ({ser_out, ser_valid, busy, frame_done, in_ready} !== exp) begin
            n_fail++;
            $display("FAIL rand cyc%0d: got out/vld/busy/fd/rdy=%b, want %b", c,
                     {ser_out, ser_valid, busy, frame_done, in_ready}, exp);
         end
         if (take) in_valid = 1'b0;
         if (!in_valid && $urandom_range(3, 0) != 0) begin
            in_valid = 1'b1; in_data = W'($urandom);
         end
         rst_n = ($urandom_range(49, 0) != 0);
         take = in_valid && rst_n && (mq.size() <= 1);
      end
      rst_n = 1'b1; in_valid = 1'b0;
      repeat (W + 1) @(negedge clk);
      $display("test_random done");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      test_reset();
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      test_word("single", 4'b1010, 4'b0101, 0);
      test_word("order",  4'b1100, 4'b0011, 0);
`else
      test_word("single", 4'b1010, 4'b1010, 1);
      test_word("order",  4'b1100, 4'b1100, 0);
`endif
      test_back_to_back();
      test_backpressure();
      test_reset_mid_word();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
